// File: rtl/mem_dump_reader.sv
// Streams a window of data-memory words out of the debug read port as bytes
// on a valid/ready channel. The window wraps inside the memory and is clipped to its depth.
module mem_dump_reader #(
    parameter int DEPTH_WORDS = 64,
    parameter bit LSB_FIRST   = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic [6:0]  num_words,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done
);
    // state   | meaning
    // S_IDLE  | waiting for start
    // S_FETCH | memory addressed, word captured at the edge
    // S_SEND  | presenting bytes of the captured word
    // S_DONE  | one-cycle completion pulse
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SEND, S_DONE} state_t;

    localparam int        AW         = $clog2(DEPTH_WORDS * 4);
    localparam logic [6:0] DEPTH_CLIP = 7'(DEPTH_WORDS);

    state_t      state, state_nxt;
    logic [31:0] addr_q, addr_inc, base_word, word_q;
    logic [6:0]  remaining_q, num_clip;
    logic [1:0]  byte_idx_q, byte_sel;
    logic        last_byte, last_word;

    assign num_clip  = (num_words > DEPTH_CLIP) ? DEPTH_CLIP : num_words;
    assign base_word = {base_addr[31:2], 2'b00};
    // Only the in-memory offset advances, so the walk wraps from the top word back to word 0.
    assign addr_inc  = {addr_q[31:AW], addr_q[AW-1:0] + AW'(4)};
    assign byte_sel  = LSB_FIRST ? byte_idx_q : (2'd3 - byte_idx_q);
    assign last_byte = (byte_idx_q == 2'd3);
    assign last_word = (remaining_q == 7'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = (num_clip == 7'd0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                state_nxt = S_SEND;
            end
            S_SEND: begin
                tx_valid = 1'b1;
                tx_data  = word_q[{byte_sel, 3'b000} +: 8];
                if (tx_ready && last_byte) begin
                    state_nxt = last_word ? S_DONE : S_FETCH;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // mem_addr is only rewritten on entry to FETCH, so it holds its last value otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= 32'd0;
            mem_addr    <= 32'd0;
            word_q      <= 32'd0;
            remaining_q <= 7'd0;
            byte_idx_q  <= 2'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        addr_q      <= base_word;
                        remaining_q <= num_clip;
                        if (num_clip != 7'd0) begin
                            mem_addr <= base_word;
                        end
                    end
                end
                S_FETCH: begin
                    word_q     <= mem_rdata;
                    byte_idx_q <= 2'd0;
                end
                S_SEND: begin
                    if (tx_ready) begin
                        if (!last_byte) begin
                            byte_idx_q <= byte_idx_q + 2'd1;
                        end else begin
                            remaining_q <= remaining_q - 7'd1;
                            addr_q      <= addr_inc;
                            if (!last_word) begin
                                mem_addr <= addr_inc;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
